// File: rtl/ex_mem_lsu.sv
// ex_mem_lsu: EX/MEM pipeline register plus load/store unit.
// Captures the EX op and drives the data-memory request/grant/rvalid handshake.
// It stalls upstream stages until the memory op completes.
// The next op is captured on the completion edge, so there is no bubble.
// Optional build macro MISALIGN_TRAP_EN adds the misalign_o output.
// With it, misaligned LH/LHU/SH/LW/SW ops complete without a memory request.
module ex_mem_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_wb_en,
   input  logic [4:0]  ex_rd_addr,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_store_data,
   input  logic [2:0]  ex_is_load,
   input  logic [1:0]  ex_is_store,
   output logic        mem_stall,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_bwe,
   output logic [31:0] dm_wdata,
   input  logic        dm_gnt,
   input  logic        dm_rvalid,
   input  logic [31:0] dm_rdata,
   output logic        wb_en_mem,
   output logic [2:0]  is_load_mem,
   output logic [4:0]  rd_addr_mem,
   output logic [31:0] alu_out_mem,
   output logic [31:0] DM_OUT
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        misalign_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDWAIT} state_t;

   state_t      state_q, state_d;
   logic        wb_en_q, wb_en_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [31:0] alu_out_q, alu_out_d;
   logic [31:0] store_data_q, store_data_d;
   logic [2:0]  is_load_q, is_load_d;
   logic [1:0]  is_store_q, is_store_d;
   logic        op_complete;
   logic        capture;
   logic        new_mem_op;
   logic        new_trap;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_q, misalign_d;
`endif

   // Byte enables for a store, placed on the lanes selected by the low address bits.
   function automatic logic [3:0] store_bwe(input logic [1:0] st, input logic [1:0] off);
      logic [3:0] bwe;
      case (st)
         2'b01:   bwe = 4'b0001 << off;
         2'b10:   bwe = 4'b0011 << {off[1], 1'b0};
         2'b11:   bwe = 4'b1111;
         default: bwe = 4'b0000;
      endcase
      return bwe;
   endfunction

   // Store data is replicated across lanes so that the byte enables alone pick the target.
   function automatic logic [31:0] store_wdata(input logic [1:0] st, input logic [31:0] data);
      logic [31:0] wd;
      case (st)
         2'b01:   wd = {4{data[7:0]}};
         2'b10:   wd = {2{data[15:0]}};
         default: wd = data;
      endcase
      return wd;
   endfunction

   // Loaded bytes are shifted down to bit 0; writeback does the sign/zero extension.
   function automatic logic [31:0] load_align(input logic [2:0] ld, input logic [1:0] off,
                                              input logic [31:0] rdata);
      logic [31:0] v;
      case (ld)
         3'b001, 3'b100: v = rdata >> {off, 3'b000};
         3'b010, 3'b101: v = rdata >> {off[1], 4'b0000};
         default:        v = rdata;
      endcase
      return v;
   endfunction

`ifdef MISALIGN_TRAP_EN
   // An access is misaligned when its low address bits do not match its size.
   function automatic logic misaligned(input logic [2:0] ld, input logic [1:0] st,
                                       input logic [1:0] off);
      logic m;
      m = 1'b0;
      if (ld == 3'b010 || ld == 3'b101 || (ld == 3'b000 && st == 2'b10)) m = off[0];
      if (ld == 3'b011 || (ld == 3'b000 && st == 2'b11))                 m = (off != 2'b00);
      return m;
   endfunction
`endif

   // FSM next state, memory handshake outputs and completion/stall decode.
   always_comb begin
      state_d     = state_q;
      op_complete = 1'b0;
      dm_req      = 1'b0;
      dm_we       = 1'b0;
      dm_bwe      = 4'b0000;
      new_mem_op  = ex_valid && (ex_is_load != 3'b000 || ex_is_store != 2'b00);
`ifdef MISALIGN_TRAP_EN
      new_trap    = ex_valid && misaligned(ex_is_load, ex_is_store, ex_alu_out[1:0]);
`else
      new_trap    = 1'b0;
`endif
      case (state_q)
         S_IDLE: op_complete = 1'b1;
         S_REQ: begin
            dm_req      = 1'b1;
            dm_we       = (is_store_q != 2'b00);
            dm_bwe      = store_bwe(is_store_q, alu_out_q[1:0]);
            op_complete = dm_gnt && (is_load_q == 3'b000);
            if (dm_gnt && is_load_q != 3'b000) state_d = S_RDWAIT;
         end
         S_RDWAIT: op_complete = dm_rvalid;
         default: state_d = S_IDLE;
      endcase
      mem_stall = (state_q != S_IDLE) && !op_complete;
      capture   = !mem_stall;
      if (capture) state_d = (new_mem_op && !new_trap) ? S_REQ : S_IDLE;
   end

   // EX/MEM field capture; ex_valid=0 loads a bubble.
   always_comb begin
      wb_en_d      = wb_en_q;
      rd_addr_d    = rd_addr_q;
      alu_out_d    = alu_out_q;
      store_data_d = store_data_q;
      is_load_d    = is_load_q;
      is_store_d   = is_store_q;
`ifdef MISALIGN_TRAP_EN
      misalign_d   = misalign_q;
`endif
      if (capture) begin
         wb_en_d      = ex_valid && ex_wb_en;
         rd_addr_d    = ex_rd_addr;
         alu_out_d    = ex_alu_out;
         store_data_d = ex_store_data;
         is_load_d    = ex_valid ? ex_is_load : 3'b000;
         is_store_d   = (ex_valid && ex_is_load == 3'b000) ? ex_is_store : 2'b00;
`ifdef MISALIGN_TRAP_EN
         misalign_d   = new_trap;
`endif
      end
   end

   // State and pipeline registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         wb_en_q      <= 1'b0;
         rd_addr_q    <= 5'd0;
         alu_out_q    <= 32'd0;
         store_data_q <= 32'd0;
         is_load_q    <= 3'd0;
         is_store_q   <= 2'd0;
`ifdef MISALIGN_TRAP_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         wb_en_q      <= wb_en_d;
         rd_addr_q    <= rd_addr_d;
         alu_out_q    <= alu_out_d;
         store_data_q <= store_data_d;
         is_load_q    <= is_load_d;
         is_store_q   <= is_store_d;
`ifdef MISALIGN_TRAP_EN
         misalign_q   <= misalign_d;
`endif
      end
   end

   assign dm_addr     = {alu_out_q[31:2], 2'b00};
   assign dm_wdata    = store_wdata(is_store_q, store_data_q);
   assign DM_OUT      = load_align(is_load_q, alu_out_q[1:0], dm_rdata);
   assign is_load_mem = is_load_q;
   assign rd_addr_mem = rd_addr_q;
   assign alu_out_mem = alu_out_q;
`ifdef MISALIGN_TRAP_EN
   assign misalign_o  = misalign_q && op_complete;
   assign wb_en_mem   = wb_en_q && op_complete && !misalign_q;
`else
   assign wb_en_mem   = wb_en_q && op_complete;
`endif

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Directed testbench for ex_mem_lsu with hand-computed expectations.
module tb_ex_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_wb_en;
   logic [4:0]  ex_rd_addr;
   logic [31:0] ex_alu_out, ex_store_data;
   logic [2:0]  ex_is_load;
   logic [1:0]  ex_is_store;
   logic        mem_stall, dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_bwe;
   logic        dm_gnt, dm_rvalid;
   logic [31:0] dm_rdata;
   logic        wb_en_mem;
   logic [2:0]  is_load_mem;
   logic [4:0]  rd_addr_mem;
   logic [31:0] alu_out_mem, DM_OUT;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ex_mem_lsu dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_rd_addr(ex_rd_addr),
      .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
      .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
      .mem_stall(mem_stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_bwe(dm_bwe), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .wb_en_mem(wb_en_mem), .is_load_mem(is_load_mem), .rd_addr_mem(rd_addr_mem),
      .alu_out_mem(alu_out_mem), .DM_OUT(DM_OUT)
`ifdef MISALIGN_TRAP_EN
      , .misalign_o(misalign_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_op(input logic wb, input logic [4:0] rd, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [2:0] ld, input logic [1:0] st);
      ex_valid      = 1'b1;
      ex_wb_en      = wb;
      ex_rd_addr    = rd;
      ex_alu_out    = alu;
      ex_store_data = sd;
      ex_is_load    = ld;
      ex_is_store   = st;
   endtask

   task automatic bubble();
      ex_valid      = 1'b0;
      ex_wb_en      = 1'b0;
      ex_rd_addr    = 5'd0;
      ex_alu_out    = 32'd0;
      ex_store_data = 32'd0;
      ex_is_load    = 3'd0;
      ex_is_store   = 2'd0;
   endtask

   initial begin
      rst = 1'b0;
      dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;
      drive_op(1'b1, 5'd5, 32'h1234, 32'd0, 3'b000, 2'b00);
      step(); step();
      check("rst_req",   dm_req, 0);
      check("rst_we",    dm_we, 0);
      check("rst_bwe",   dm_bwe, 0);
      check("rst_stall", mem_stall, 0);
      check("rst_wb",    wb_en_mem, 0);
      check("rst_islm",  is_load_mem, 0);
      check("rst_rd",    rd_addr_mem, 0);
      check("rst_alu",   alu_out_mem, 0);
      bubble();
      rst = 1'b1;
      step();

      // ALU op passes straight through
      drive_op(1'b1, 5'd5, 32'h1234, 32'd0, 3'b000, 2'b00);
      step();
      bubble();
      check("add_wb",    wb_en_mem, 1);
      check("add_alu",   alu_out_mem, 32'h1234);
      check("add_rd",    rd_addr_mem, 5);
      check("add_stall", mem_stall, 0);
      step();
      check("bubble_wb", wb_en_mem, 0);

      // SB to 0x103, grant after two stalled cycles, ALU op waiting behind it
      drive_op(1'b0, 5'd0, 32'h103, 32'h123456AB, 3'b000, 2'b01);
      step();
      drive_op(1'b1, 5'd7, 32'h77, 32'd0, 3'b000, 2'b00);
      check("sb_req",    dm_req, 1);
      check("sb_we",     dm_we, 1);
      check("sb_addr",   dm_addr, 32'h100);
      check("sb_bwe",    dm_bwe, 4'b1000);
      check("sb_wdata",  dm_wdata, 32'hABABABAB);
      check("sb_stall1", mem_stall, 1);
      check("sb_wb",     wb_en_mem, 0);
      step();
      check("sb_stall2", mem_stall, 1);
      check("sb_addr2",  dm_addr, 32'h100);
      check("sb_bwe2",   dm_bwe, 4'b1000);
      step();
      dm_gnt = 1'b1;
      #1;
      check("sb_gnt_stall", mem_stall, 0);
      check("sb_gnt_wb",    wb_en_mem, 0);
      check("sb_gnt_req",   dm_req, 1);
      step();
      dm_gnt = 1'b0;
      bubble();
      check("sb_next_rd",  rd_addr_mem, 7);
      check("sb_next_alu", alu_out_mem, 32'h77);
      check("sb_next_wb",  wb_en_mem, 1);
      check("sb_next_req", dm_req, 0);
      step();

      // SH to 0x206 and SW to 0x300
      drive_op(1'b0, 5'd0, 32'h206, 32'h1234CDEF, 3'b000, 2'b10);
      step();
      bubble();
      dm_gnt = 1'b1;
      #1;
      check("sh_bwe",   dm_bwe, 4'b1100);
      check("sh_wdata", dm_wdata, 32'hCDEFCDEF);
      check("sh_addr",  dm_addr, 32'h204);
      step();
      dm_gnt = 1'b0;
      check("sh_done_req", dm_req, 0);
      drive_op(1'b0, 5'd0, 32'h300, 32'hDEADBEEF, 3'b000, 2'b11);
      step();
      bubble();
      dm_gnt = 1'b1;
      #1;
      check("sw_bwe",   dm_bwe, 4'b1111);
      check("sw_wdata", dm_wdata, 32'hDEADBEEF);
      step();
      dm_gnt = 1'b0;

      // LH at 0x202: immediate grant, rvalid one cycle later
      drive_op(1'b1, 5'd9, 32'h202, 32'd0, 3'b010, 2'b00);
      step();
      bubble();
      dm_gnt = 1'b1;
      #1;
      check("lh_we",        dm_we, 0);
      check("lh_bwe",       dm_bwe, 0);
      check("lh_addr",      dm_addr, 32'h200);
      check("lh_stall_gnt", mem_stall, 1);
      check("lh_wb_gnt",    wb_en_mem, 0);
      step();
      dm_gnt = 1'b0;
      check("lh_rdw_req",   dm_req, 0);
      check("lh_rdw_stall", mem_stall, 1);
      check("lh_islm",      is_load_mem, 3'b010);
      check("lh_rdw_wb",    wb_en_mem, 0);
      dm_rvalid = 1'b1;
      dm_rdata  = 32'hBEEF0000;
      #1;
      check("lh_dm_out", {16'd0, DM_OUT[15:0]}, 32'hBEEF);
      check("lh_wb",     wb_en_mem, 1);
      check("lh_stall",  mem_stall, 0);
      check("lh_rd",     rd_addr_mem, 9);
      step();
      dm_rvalid = 1'b0;
      check("lh_after_wb", wb_en_mem, 0);

      // byte and halfword lane selection on rdata 0x11223344
      drive_op(1'b1, 5'd2, 32'h401, 32'd0, 3'b100, 2'b00);
      step(); bubble(); dm_gnt = 1'b1;
      step(); dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h11223344;
      #1;
      check("lbu_401", {24'd0, DM_OUT[7:0]}, 32'h33);
      step(); dm_rvalid = 1'b0;
      drive_op(1'b1, 5'd2, 32'h403, 32'd0, 3'b001, 2'b00);
      step(); bubble(); dm_gnt = 1'b1;
      step(); dm_gnt = 1'b0; dm_rvalid = 1'b1;
      #1;
      check("lb_403", {24'd0, DM_OUT[7:0]}, 32'h11);
      step(); dm_rvalid = 1'b0;
      drive_op(1'b1, 5'd2, 32'h400, 32'd0, 3'b101, 2'b00);
      step(); bubble(); dm_gnt = 1'b1;
      step(); dm_gnt = 1'b0; dm_rvalid = 1'b1;
      #1;
      check("lhu_400", {16'd0, DM_OUT[15:0]}, 32'h3344);
      step(); dm_rvalid = 1'b0;

      // LW followed by ALU op: ALU op captured on the rvalid edge
      drive_op(1'b1, 5'd3, 32'h500, 32'd0, 3'b011, 2'b00);
      step();
      drive_op(1'b1, 5'd4, 32'hABC, 32'd0, 3'b000, 2'b00);
      dm_gnt = 1'b1;
      step();
      dm_gnt = 1'b0;
      check("lw_wait_stall", mem_stall, 1);
      step();
      check("lw_wait2_stall", mem_stall, 1);
      check("lw_wait2_rd",    rd_addr_mem, 3);
      dm_rvalid = 1'b1;
      dm_rdata  = 32'hCAFEF00D;
      #1;
      check("lw_dm_out", DM_OUT, 32'hCAFEF00D);
      check("lw_wb",     wb_en_mem, 1);
      check("lw_rd",     rd_addr_mem, 3);
      step();
      dm_rvalid = 1'b0;
      check("b2b_rd",    rd_addr_mem, 4);
      check("b2b_alu",   alu_out_mem, 32'hABC);
      check("b2b_wb",    wb_en_mem, 1);
      check("b2b_stall", mem_stall, 0);
      bubble();
      step();
      dm_rvalid = 1'b1;
      dm_gnt    = 1'b1;
      #1;
      check("stray_req",   dm_req, 0);
      check("stray_stall", mem_stall, 0);
      step();
      dm_rvalid = 1'b0;
      dm_gnt    = 1'b0;
      check("stray_wb",   wb_en_mem, 0);
      check("stray_rd",   rd_addr_mem, 0);
      check("stray_req2", dm_req, 0);

      // load and store both set: treated as a load
      drive_op(1'b1, 5'd8, 32'h600, 32'h55, 3'b011, 2'b11);
      step();
      bubble();
      #1;
      check("ls_req",  dm_req, 1);
      check("ls_we",   dm_we, 0);
      check("ls_bwe",  dm_bwe, 0);
      check("ls_islm", is_load_mem, 3'b011);
      dm_gnt = 1'b1;
      step();
      dm_gnt = 1'b0;
      check("ls_rdwait_stall", mem_stall, 1);
      dm_rvalid = 1'b1;
      dm_rdata  = 32'h600DF00D;
      #1;
      check("ls_wb", wb_en_mem, 1);
      step();
      dm_rvalid = 1'b0;

      // reset asserted while waiting for rvalid
      drive_op(1'b1, 5'd6, 32'h700, 32'd0, 3'b011, 2'b00);
      step();
      bubble();
      dm_gnt = 1'b1;
      step();
      dm_gnt = 1'b0;
      check("rst_pre_stall", mem_stall, 1);
      rst = 1'b0;
      #1;
      check("rst_mid_req",   dm_req, 0);
      check("rst_mid_stall", mem_stall, 0);
      check("rst_mid_alu",   alu_out_mem, 0);
      check("rst_mid_rd",    rd_addr_mem, 0);
      check("rst_mid_islm",  is_load_mem, 0);
      step();
      rst = 1'b1;
      step();
      dm_rvalid = 1'b1;
      dm_rdata  = 32'hFFFFFFFF;
      #1;
      check("late_wb",    wb_en_mem, 0);
      check("late_stall", mem_stall, 0);
      check("late_req",   dm_req, 0);
      step();
      dm_rvalid = 1'b0;
      check("late_alu", alu_out_mem, 0);
      check("late_rd",  rd_addr_mem, 0);

      // LW to misaligned address 0x101
      drive_op(1'b1, 5'd10, 32'h101, 32'd0, 3'b011, 2'b00);
      step();
      bubble();
      #1;
`ifdef MISALIGN_TRAP_EN
      check("mis_o",     misalign_o, 1);
      check("mis_req",   dm_req, 0);
      check("mis_wb",    wb_en_mem, 0);
      check("mis_stall", mem_stall, 0);
      step();
      check("mis_o_after", misalign_o, 0);
`else
      check("mis_req",  dm_req, 1);
      check("mis_addr", dm_addr, 32'h100);
      dm_gnt = 1'b1;
      step();
      dm_gnt = 1'b0;
      dm_rvalid = 1'b1;
      dm_rdata  = 32'h89ABCDEF;
      #1;
      check("mis_dm_out", DM_OUT, 32'h89ABCDEF);
      check("mis_wb",     wb_en_mem, 1);
      step();
      dm_rvalid = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
